// File: rtl/dsp_isa_pkg.sv
// Shared DSP instruction-set constants: default field widths, the long-form
// opcode prefix, and the decode-stage state encoding.
package dsp_isa_pkg;

    localparam int INSTR_W = 16;
    localparam int OPS_W   = 4;
    localparam int OPDK_W  = 8;
    localparam int D_W     = 7;
    localparam int K_W     = 8;
    localparam int AR_W    = 3;

    // Short opcode value announcing that an extension word follows.
    localparam logic [3:0] LONG_PREFIX = 4'hB;

    // ST_OP waits for an opcode word, ST_EXT waits for the extension word.
    typedef enum logic {
        ST_OP  = 1'b0,
        ST_EXT = 1'b1
    } state_e;

endpackage

// File: rtl/instr_field_split.sv
// Pure combinational slicing of one instruction word into its decode fields.
// No sign extension and no legality checking; every field is a bit slice.
module instr_field_split #(
    parameter int INSTR_W = dsp_isa_pkg::INSTR_W,
    parameter int OPS_W   = dsp_isa_pkg::OPS_W,
    parameter int OPDK_W  = dsp_isa_pkg::OPDK_W,
    parameter int D_W     = dsp_isa_pkg::D_W,
    parameter int K_W     = dsp_isa_pkg::K_W,
    parameter int AR_W    = dsp_isa_pkg::AR_W
) (
    input  logic [INSTR_W-1:0] word,
    output logic [OPDK_W-1:0]  op_dk,
    output logic [OPS_W-1:0]   op_s,
    output logic [3:0]         s_field,
    output logic [D_W-1:0]     d_addr,
    output logic [K_W-1:0]     k_imm,
    output logic               indirect,
    output logic [AR_W-1:0]    ar_sel
);

    // Each field is a fixed window of the word; fields overlap by design.
    always_comb begin
        op_dk    = word[INSTR_W-1 -: OPDK_W];
        op_s     = word[INSTR_W-1 -: OPS_W];
        s_field  = word[INSTR_W-OPS_W-1 -: 4];
        d_addr   = word[D_W-1:0];
        k_imm    = word[K_W-1:0];
        indirect = word[7];
        ar_sel   = word[AR_W-1:0];
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage between fetch and the DSP datapath.
// Short instructions decode in one cycle; a word whose op_s equals the long
// prefix is held until its extension word arrives, then both are emitted as
// one bundle. Valid/ready on both sides; flush drops in-flight state.
module instr_decode_stage #(
    parameter int INSTR_W = dsp_isa_pkg::INSTR_W,
    parameter int OPS_W   = dsp_isa_pkg::OPS_W,
    parameter int OPDK_W  = dsp_isa_pkg::OPDK_W,
    parameter int D_W     = dsp_isa_pkg::D_W,
    parameter int K_W     = dsp_isa_pkg::K_W,
    parameter int AR_W    = dsp_isa_pkg::AR_W,
    parameter logic [OPS_W-1:0] LONG_PREFIX = dsp_isa_pkg::LONG_PREFIX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_word,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OPDK_W-1:0]  op_dk,
    output logic [OPS_W-1:0]   op_s,
    output logic [3:0]         s_field,
    output logic [D_W-1:0]     d_addr,
    output logic [K_W-1:0]     k_imm,
    output logic               indirect,
    output logic [AR_W-1:0]    ar_sel,
    output logic               is_long,
    output logic [INSTR_W-1:0] long_imm,
    output logic [INSTR_W-1:0] raw
);

    import dsp_isa_pkg::*;

    if (!(OPS_W <= OPDK_W && OPDK_W < INSTR_W && K_W >= 8 &&
          K_W <= INSTR_W && AR_W <= K_W)) begin : g_param_check
        $error("instr_decode_stage: illegal field width parameters");
    end

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   held_q, held_d;
    logic                 out_valid_q, out_valid_d;
    logic [OPDK_W-1:0]    op_dk_q, op_dk_d;
    logic [OPS_W-1:0]     op_s_q, op_s_d;
    logic [3:0]           s_field_q, s_field_d;
    logic [D_W-1:0]       d_addr_q, d_addr_d;
    logic [K_W-1:0]       k_imm_q, k_imm_d;
    logic                 indirect_q, indirect_d;
    logic [AR_W-1:0]      ar_sel_q, ar_sel_d;
    logic                 is_long_q, is_long_d;
    logic [INSTR_W-1:0]   long_imm_q, long_imm_d;
    logic [INSTR_W-1:0]   raw_q, raw_d;

    logic [INSTR_W-1:0]   first_word;
    logic [OPDK_W-1:0]    sp_op_dk;
    logic [OPS_W-1:0]     sp_op_s;
    logic [3:0]           sp_s_field;
    logic [D_W-1:0]       sp_d_addr;
    logic [K_W-1:0]       sp_k_imm;
    logic                 sp_indirect;
    logic [AR_W-1:0]      sp_ar_sel;
    logic                 accept;

    // The splitter sees the held first word while waiting for an extension,
    // otherwise the word currently offered by fetch.
    always_comb begin
        first_word = (state_q == ST_EXT) ? held_q : in_word;
        in_ready   = !reset && !flush && (!out_valid_q || out_ready);
        accept     = in_valid && in_ready;
    end

    instr_field_split #(
        .INSTR_W (INSTR_W),
        .OPS_W   (OPS_W),
        .OPDK_W  (OPDK_W),
        .D_W     (D_W),
        .K_W     (K_W),
        .AR_W    (AR_W)
    ) u_split (
        .word     (first_word),
        .op_dk    (sp_op_dk),
        .op_s     (sp_op_s),
        .s_field  (sp_s_field),
        .d_addr   (sp_d_addr),
        .k_imm    (sp_k_imm),
        .indirect (sp_indirect),
        .ar_sel   (sp_ar_sel)
    );

    // Next-state and bundle load: flush wins, then an accepted word either
    // starts a long instruction, completes one, or decodes a short one.
    always_comb begin
        state_d     = state_q;
        held_d      = held_q;
        out_valid_d = out_valid_q && !out_ready;
        op_dk_d     = op_dk_q;
        op_s_d      = op_s_q;
        s_field_d   = s_field_q;
        d_addr_d    = d_addr_q;
        k_imm_d     = k_imm_q;
        indirect_d  = indirect_q;
        ar_sel_d    = ar_sel_q;
        is_long_d   = is_long_q;
        long_imm_d  = long_imm_q;
        raw_d       = raw_q;

        if (flush) begin
            state_d     = ST_OP;
            out_valid_d = 1'b0;
        end else if (accept) begin
            if (state_q == ST_OP && sp_op_s == LONG_PREFIX) begin
                held_d  = in_word;
                state_d = ST_EXT;
            end else begin
                op_dk_d     = sp_op_dk;
                op_s_d      = sp_op_s;
                s_field_d   = sp_s_field;
                d_addr_d    = sp_d_addr;
                k_imm_d     = sp_k_imm;
                indirect_d  = sp_indirect;
                ar_sel_d    = sp_ar_sel;
                raw_d       = first_word;
                out_valid_d = 1'b1;
                state_d     = ST_OP;
                if (state_q == ST_EXT) begin
                    is_long_d  = 1'b1;
                    long_imm_d = in_word;
                end else begin
                    is_long_d  = 1'b0;
                    long_imm_d = '0;
                end
            end
        end
    end

    // State, held word and output register slice; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_OP;
            held_q      <= '0;
            out_valid_q <= 1'b0;
            op_dk_q     <= '0;
            op_s_q      <= '0;
            s_field_q   <= '0;
            d_addr_q    <= '0;
            k_imm_q     <= '0;
            indirect_q  <= 1'b0;
            ar_sel_q    <= '0;
            is_long_q   <= 1'b0;
            long_imm_q  <= '0;
            raw_q       <= '0;
        end else begin
            state_q     <= state_d;
            held_q      <= held_d;
            out_valid_q <= out_valid_d;
            op_dk_q     <= op_dk_d;
            op_s_q      <= op_s_d;
            s_field_q   <= s_field_d;
            d_addr_q    <= d_addr_d;
            k_imm_q     <= k_imm_d;
            indirect_q  <= indirect_d;
            ar_sel_q    <= ar_sel_d;
            is_long_q   <= is_long_d;
            long_imm_q  <= long_imm_d;
            raw_q       <= raw_d;
        end
    end

    // Outputs come straight from the register slice.
    always_comb begin
        out_valid = out_valid_q;
        op_dk     = op_dk_q;
        op_s      = op_s_q;
        s_field   = s_field_q;
        d_addr    = d_addr_q;
        k_imm     = k_imm_q;
        indirect  = indirect_q;
        ar_sel    = ar_sel_q;
        is_long   = is_long_q;
        long_imm  = long_imm_q;
        raw       = raw_q;
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: hand-computed vector table for the
// handshake/decode flow plus hand sequences for reset, flush and long words.
module tb_instr_decode_stage;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [15:0] inWord;
    logic        outValid;
    logic        outReady;
    logic [7:0]  opDk;
    logic [3:0]  opS;
    logic [3:0]  sField;
    logic [6:0]  dAddr;
    logic [7:0]  kImm;
    logic        indirect;
    logic [2:0]  arSel;
    logic        isLong;
    logic [15:0] longImm;
    logic [15:0] raw;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic        flush;
        logic        inValid;
        logic [15:0] inWord;
        logic        outReady;
        logic        expInReady;
        logic        expValid;
        logic [3:0]  expOpS;
        logic [7:0]  expK;
        logic        expLong;
        logic [15:0] expLongImm;
        logic [15:0] expRaw;
    } vec_t;

    vec_t vecs[14];

    instr_decode_stage dut (
        .clk       (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_word   (inWord),
        .out_valid (outValid),
        .out_ready (outReady),
        .op_dk     (opDk),
        .op_s      (opS),
        .s_field   (sField),
        .d_addr    (dAddr),
        .k_imm     (kImm),
        .indirect  (indirect),
        .ar_sel    (arSel),
        .is_long   (isLong),
        .long_imm  (longImm),
        .raw       (raw)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive inputs on the falling edge so they are stable at the next rise.
    task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                 input logic [15:0] word, input logic ordy);
        @(negedge clock);
        reset    = rst;
        flush    = fl;
        inValid  = iv;
        inWord   = word;
        outReady = ordy;
        #1;
    endtask

    // Advance through one rising edge and sample shortly after it.
    task automatic stepEdge();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAllFields(input string tag, input logic [7:0] eOpDk,
                                  input logic [3:0] eOpS, input logic [3:0] eS,
                                  input logic [6:0] eD, input logic [7:0] eK,
                                  input logic eInd, input logic [2:0] eAr,
                                  input logic eLong, input logic [15:0] eLongImm,
                                  input logic [15:0] eRaw);
        checkOutput({tag, " op_dk"}, opDk, eOpDk);
        checkOutput({tag, " op_s"}, opS, eOpS);
        checkOutput({tag, " s_field"}, sField, eS);
        checkOutput({tag, " d_addr"}, dAddr, eD);
        checkOutput({tag, " k_imm"}, kImm, eK);
        checkOutput({tag, " indirect"}, indirect, eInd);
        checkOutput({tag, " ar_sel"}, arSel, eAr);
        checkOutput({tag, " is_long"}, isLong, eLong);
        checkOutput({tag, " long_imm"}, longImm, eLongImm);
        checkOutput({tag, " raw"}, raw, eRaw);
    endtask

    initial begin
        // flush, valid, word, ready | in_ready, valid, op_s, k, long, long_imm, raw
        vecs[0]  = '{1'b0, 1'b1, 16'h3C40, 1'b1, 1'b1, 1'b1, 4'h3, 8'h40, 1'b0, 16'h0000, 16'h3C40};
        vecs[1]  = '{1'b0, 1'b1, 16'hB312, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 16'h0000, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 4'hB, 8'h12, 1'b1, 16'h1234, 16'hB312};
        vecs[3]  = '{1'b0, 1'b1, 16'h4C07, 1'b1, 1'b1, 1'b1, 4'h4, 8'h07, 1'b0, 16'h0000, 16'h4C07};
        vecs[4]  = '{1'b0, 1'b1, 16'h5D88, 1'b0, 1'b0, 1'b1, 4'h4, 8'h07, 1'b0, 16'h0000, 16'h4C07};
        vecs[5]  = '{1'b0, 1'b1, 16'h5D88, 1'b0, 1'b0, 1'b1, 4'h4, 8'h07, 1'b0, 16'h0000, 16'h4C07};
        vecs[6]  = '{1'b0, 1'b1, 16'h5D88, 1'b0, 1'b0, 1'b1, 4'h4, 8'h07, 1'b0, 16'h0000, 16'h4C07};
        vecs[7]  = '{1'b0, 1'b1, 16'h5D88, 1'b1, 1'b1, 1'b1, 4'h5, 8'h88, 1'b0, 16'h0000, 16'h5D88};
        vecs[8]  = '{1'b0, 1'b1, 16'h6E01, 1'b1, 1'b1, 1'b1, 4'h6, 8'h01, 1'b0, 16'h0000, 16'h6E01};
        vecs[9]  = '{1'b0, 1'b1, 16'hB312, 1'b0, 1'b0, 1'b1, 4'h6, 8'h01, 1'b0, 16'h0000, 16'h6E01};
        vecs[10] = '{1'b0, 1'b1, 16'hB312, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 16'h0000, 16'h0000};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 16'h0000, 16'h0000};
        vecs[12] = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 4'hB, 8'h12, 1'b1, 16'h1234, 16'hB312};
        vecs[13] = '{1'b1, 1'b1, 16'h7777, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 16'h0000, 16'h0000};

        reset    = 1'b1;
        flush    = 1'b0;
        inValid  = 1'b0;
        inWord   = 16'h0000;
        outReady = 1'b0;

        // Reset held for two edges, then released.
        stepEdge();
        stepEdge();
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("reset out_valid", outValid, 1'b0);
        checkOutput("reset in_ready", inReady, 1'b1);
        checkAllFields("reset", 8'h00, 4'h0, 4'h0, 7'h00, 8'h00, 1'b0, 3'h0, 1'b0, 16'h0000, 16'h0000);

        // Single short word, every field checked.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h2A85, 1'b1);
        stepEdge();
        checkOutput("short out_valid", outValid, 1'b1);
        checkAllFields("short", 8'h2A, 4'h2, 4'hA, 7'h05, 8'h85, 1'b1, 3'h5, 1'b0, 16'h0000, 16'h2A85);

        // Table: streaming, long words, stalls, and a flush.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, vecs[i].flush, vecs[i].inValid, vecs[i].inWord, vecs[i].outReady);
            checkOutput($sformatf("vec%0d in_ready", i), inReady, vecs[i].expInReady);
            stepEdge();
            checkOutput($sformatf("vec%0d out_valid", i), outValid, vecs[i].expValid);
            if (vecs[i].expValid) begin
                checkOutput($sformatf("vec%0d op_s", i), opS, vecs[i].expOpS);
                checkOutput($sformatf("vec%0d k_imm", i), kImm, vecs[i].expK);
                checkOutput($sformatf("vec%0d is_long", i), isLong, vecs[i].expLong);
                checkOutput($sformatf("vec%0d long_imm", i), longImm, vecs[i].expLongImm);
                checkOutput($sformatf("vec%0d raw", i), raw, vecs[i].expRaw);
            end
        end

        // Flush while waiting for an extension word: next word decodes short.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hB312, 1'b1);
        stepEdge();
        checkOutput("flushext prefix out_valid", outValid, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("flushext in_ready", inReady, 1'b0);
        stepEdge();
        checkOutput("flushext out_valid", outValid, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
        stepEdge();
        checkOutput("flushext short out_valid", outValid, 1'b1);
        checkAllFields("flushext", 8'h12, 4'h1, 4'h2, 7'h34, 8'h34, 1'b0, 3'h4, 1'b0, 16'h0000, 16'h1234);

        // Reset with a stalled valid bundle: everything clears, nothing reappears.
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h2A85, 1'b0);
        checkOutput("rstbundle in_ready", inReady, 1'b0);
        stepEdge();
        checkOutput("rstbundle out_valid", outValid, 1'b0);
        checkAllFields("rstbundle", 8'h00, 4'h0, 4'h0, 7'h00, 8'h00, 1'b0, 3'h0, 1'b0, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        stepEdge();
        checkOutput("rstbundle after1 out_valid", outValid, 1'b0);
        stepEdge();
        checkOutput("rstbundle after2 out_valid", outValid, 1'b0);

        // Reset between the two words of a long instruction drops the prefix.
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hB312, 1'b1);
        stepEdge();
        checkOutput("rstlong prefix out_valid", outValid, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        stepEdge();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1234, 1'b1);
        stepEdge();
        checkOutput("rstlong out_valid", outValid, 1'b1);
        checkOutput("rstlong op_s", opS, 4'h1);
        checkOutput("rstlong is_long", isLong, 1'b0);
        checkOutput("rstlong raw", raw, 16'h1234);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
